dmem_arbiter: RTL and testbench

//  Shares the single data_memory port between N requesters: port 0 is the CPU load/store path, port 1 the serial program loader.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 63 ++++++
 rtl/dmem_arbiter_rr_pick.sv | 42 ++++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module : dmem_arbiter_pkg
//  Brief  : Shared types and default sizes for the data-memory arbiter.
//           Provides the sequencer state encoding and default widths.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  localparam int DEF_N_REQ = 2;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module : dmem_arbiter_if
//  Brief  : Requester/memory bus bundle of the data-memory arbiter.
//           master : requesters plus data_memory read-data return
//           slave  : the arbiter itself
//  Ports  : req/req_addr/req_wdata/req_we/req_size (flat per-port payload),
//           gnt/rvalid/rdata (per-port handshake), mem_* (to data_memory),
//           busy; grant_count/conflict_count when DMEM_ARB_PERF_EN defined.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*2-1:0]  req_size;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_re;
  logic                mem_we;
  logic [1:0]          mem_size;
  logic [DW-1:0]       mem_rdata;
  logic                busy;
`ifdef DMEM_ARB_PERF_EN
  logic [N_REQ*CNT_W-1:0] grant_count;
  logic [CNT_W-1:0]       conflict_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

  modport master (
    output req, req_addr, req_wdata, req_we, req_size, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_re, mem_we, mem_size, busy
`ifdef DMEM_ARB_PERF_EN
    , input grant_count, conflict_count
`endif
  );

  modport slave (
    input  req, req_addr, req_wdata, req_we, req_size, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_re, mem_we, mem_size, busy
`ifdef DMEM_ARB_PERF_EN
    , output grant_count, conflict_count
`endif
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin picker. Searches i_req starting at
//           i_ptr, wrapping modulo N_REQ, and reports the first set bit.
//  Ports  : i_req (request vector), i_ptr (search start),
//           o_win (one-hot winner, 0 if none), o_win_idx (winner index)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic [IDX_W-1:0] o_win_idx
);

  always_comb begin
    int   w_j;
    logic w_found;
    o_win     = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // Candidate position ptr+k folded back into 0..N_REQ-1.
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found        = 1'b1;
        o_win[w_j]     = 1'b1;
        o_win_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module : dmem_arbiter
//  Brief  : Shares the single data_memory port between N_REQ requesters
//           (port 0 CPU load/store, port 1 serial loader). Round-robin
//           arbitration with an IDLE/ISSUE/RESP sequencer, one access in
//           flight. Optional perf counters under macro DMEM_ARB_PERF_EN.
//  Ports  : clock, reset (synchronous, active-high),
//           bus (dmem_arbiter_if.slave: request payload, gnt/rvalid/rdata,
//           mem_* to data_memory, busy, optional counters)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win_idx;
  logic             r_we;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_rvalid;
  logic [DW-1:0]    r_rdata;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic             r_mem_re;
  logic             r_mem_we;
  logic [1:0]       r_mem_size;
  logic             r_busy;

  logic [N_REQ-1:0] w_win;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_we;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx)
  );

  assign w_win_we = bus.req_we[w_win_idx];

  // Sequencer. The mem_* output registers double as the latched payload:
  // they are loaded on IDLE exit so they are already valid during ISSUE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win_idx   <= '0;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= '0;
      r_busy      <= 1'b0;
    end else begin
      // Every strobe is a single-cycle pulse unless set below.
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= '0;
      case (r_state)
        ST_IDLE: begin
          // rdata is only meaningful alongside rvalid; return it to zero
          // so an idle arbiter presents its reset values.
          r_rdata <= '0;
          if (|bus.req) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_win_idx   <= w_win_idx;
            r_we        <= w_win_we;
            r_gnt       <= w_win;
            r_mem_addr  <= bus.req_addr[w_win_idx*AW +: AW];
            r_mem_wdata <= bus.req_wdata[w_win_idx*DW +: DW];
            r_mem_size  <= bus.req_size[w_win_idx*2 +: 2];
            r_mem_re    <= ~w_win_we;
            r_mem_we    <= w_win_we;
          end
        end
        ST_ISSUE: begin
          r_ptr   <= (r_win_idx == IDX_W'(N_REQ - 1)) ? '0 : r_win_idx + 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_rdata             <= r_we ? '0 : bus.mem_rdata;
          r_rvalid[r_win_idx] <= 1'b1;
          r_busy              <= 1'b0;
          r_state             <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_size  = r_mem_size;
  assign bus.busy      = r_busy;

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] r_grant_count [N_REQ];
  logic [CNT_W-1:0] r_conflict_count;
  logic             w_multi_req;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi_req = (bus.req & (bus.req - 1'b1)) != '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
    always_ff @(posedge clock) begin
      if (reset) begin
        r_grant_count[gi] <= '0;
      end else if (r_state == ST_ISSUE && r_win_idx == IDX_W'(gi)
                   && !(&r_grant_count[gi])) begin
        r_grant_count[gi] <= r_grant_count[gi] + 1'b1;
      end
    end
    assign bus.grant_count[gi*CNT_W +: CNT_W] = r_grant_count[gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_conflict_count <= '0;
    end else if (r_state == ST_IDLE && w_multi_req && !(&r_conflict_count)) begin
      r_conflict_count <= r_conflict_count + 1'b1;
    end
  end

  assign bus.conflict_count = r_conflict_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module : tb_dmem_arbiter
//  Brief  : Self-checking bench for dmem_arbiter. A transaction-level model
//           predicts per-cycle outputs; directed scenarios add literal
//           expectations; a randomized phase exercises contention and reset.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int MAXC = 2048;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW), .CNT_W(CW)) bus ();

  dmem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'hA5A5_0000 + 32'(i);
  endfunction

  // ---------------- data_memory stand-in (reacts to the DUT) ----------------
  logic [31:0] env_mem  [16];
  bit          env_flag [16];
  initial begin
    forever begin
      @(posedge clock);
      if (bus.mem_re)
        bus.mem_rdata <= env_flag[bus.mem_addr[5:2]] ? env_mem[bus.mem_addr[5:2]]
                                                     : init_val(int'(bus.mem_addr[5:2]));
      if (bus.mem_we) begin
        env_mem[bus.mem_addr[5:2]]  = bus.mem_wdata;
        env_flag[bus.mem_addr[5:2]] = 1'b1;
      end
    end
  end

  // ---------------- behavioural model: expected outputs per cycle ----------------
  logic [N-1:0]  e_gnt    [MAXC];
  logic [N-1:0]  e_rvalid [MAXC];
  logic          e_re     [MAXC];
  logic          e_we     [MAXC];
  logic          e_busy   [MAXC];
  logic [AW-1:0] e_addr   [MAXC];
  logic [DW-1:0] e_wdata  [MAXC];
  logic [1:0]    e_size   [MAXC];
  logic [DW-1:0] e_rdata  [MAXC];
  logic [31:0]   sh_mem   [16];
  bit            sh_flag  [16];
  int            m_gcnt   [N];
  int            m_conf;

  task automatic clr(input int k);
    if (k < MAXC) begin
      e_gnt[k] = '0; e_rvalid[k] = '0; e_re[k] = 1'b0; e_we[k] = 1'b0; e_busy[k] = 1'b0;
      e_addr[k] = '0; e_wdata[k] = '0; e_size[k] = '0; e_rdata[k] = '0;
    end
  endtask

  initial begin
    int t, free_at, ptr, w, c, idx;
    logic we;
    logic [AW-1:0] a;
    free_at = 0; ptr = 0; m_conf = 0;
    forever begin
      @(posedge clock);
      t   = cyc;          // cycle that ends at this edge
      cyc = cyc + 1;
      if (reset) begin
        if (!chk_en) begin
          for (int k = 0; k < MAXC; k++) clr(k);
        end else begin
          for (int k = cyc; k < cyc + 4; k++) clr(k);
        end
        chk_en = 1'b1;
        ptr = 0; free_at = cyc; m_conf = 0;
        for (int p = 0; p < N; p++) m_gcnt[p] = 0;
      end else if (chk_en && t >= free_at && t + 3 < MAXC) begin
        if ($countones(bus.req) > 1) m_conf++;
        w = -1;
        for (int k = 0; k < N; k++) begin
          c = (ptr + k) % N;
          if (w < 0 && bus.req[c]) w = c;
        end
        if (w >= 0) begin
          we  = bus.req_we[w];
          a   = bus.req_addr[w*AW +: AW];
          idx = int'(a[5:2]);
          e_gnt[t+1]   = N'(1) << w;
          e_re[t+1]    = ~we;
          e_we[t+1]    = we;
          e_addr[t+1]  = a;
          e_wdata[t+1] = bus.req_wdata[w*DW +: DW];
          e_size[t+1]  = bus.req_size[w*2 +: 2];
          e_busy[t+1]  = 1'b1;
          e_busy[t+2]  = 1'b1;
          e_rvalid[t+3] = N'(1) << w;
          e_rdata[t+3]  = we ? '0 : (sh_flag[idx] ? sh_mem[idx] : init_val(idx));
          if (we) begin
            sh_mem[idx]  = bus.req_wdata[w*DW +: DW];
            sh_flag[idx] = 1'b1;
          end
          ptr     = (w + 1) % N;
          free_at = t + 3;
          m_gcnt[w]++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en && cyc < MAXC) begin
        chk("gnt",    bus.gnt,    e_gnt[cyc]);
        chk("rvalid", bus.rvalid, e_rvalid[cyc]);
        chk("mem_re", bus.mem_re, e_re[cyc]);
        chk("mem_we", bus.mem_we, e_we[cyc]);
        chk("busy",   bus.busy,   e_busy[cyc]);
        if (e_gnt[cyc] != '0) begin
          chk("mem_addr",  bus.mem_addr,  e_addr[cyc]);
          chk("mem_wdata", bus.mem_wdata, e_wdata[cyc]);
          chk("mem_size",  bus.mem_size,  e_size[cyc]);
        end
        if (e_rvalid[cyc] != '0) chk("rdata", bus.rdata, e_rdata[cyc]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size);
    bus.req[p]                 = 1'b1;
    bus.req_we[p]              = we;
    bus.req_addr[p*AW +: AW]   = addr;
    bus.req_wdata[p*DW +: DW]  = wdata;
    bus.req_size[p*2 +: 2]     = size;
  endtask

  task automatic rand_payload(input int p);
    drive(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
          $urandom(), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    int ng, order[4], gc[4];
    bus.req = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = '0; bus.req_size = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_gnt", bus.gnt, '0);
    chk("reset_rdata", bus.rdata, '0);
    reset = 1'b0;
    @(negedge clock);

    // Single read from port 0.
    drive(0, 1'b0, 32'h10, 32'h0, 2'b10);
    @(negedge clock);
    chk("rd_gnt", bus.gnt, 2'b01);
    chk("rd_mem_re", bus.mem_re, 1'b1);
    chk("rd_mem_addr", bus.mem_addr, 32'h10);
    chk("rd_model_gnt", e_gnt[cyc], 2'b01);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("rd_rvalid", bus.rvalid, 2'b01);
    chk("rd_rdata", bus.rdata, 32'hDEADBEEF);
    chk("rd_model_rdata", e_rdata[cyc], 32'hDEADBEEF);

    // Single write from port 1, launched in the rvalid cycle.
    drive(1, 1'b1, 32'h20, 32'h12345678, 2'b10);
    @(negedge clock);
    chk("wr_gnt", bus.gnt, 2'b10);
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 32'h20);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    bus.req[1] = 1'b0;
    @(negedge clock);
    chk("wr_we_one_cycle", bus.mem_we, 1'b0);
    @(negedge clock);
    chk("wr_rvalid", bus.rvalid, 2'b10);
    chk("wr_rdata", bus.rdata, 32'h0);

    // Contention from reset.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 32'h4, 32'h0, 2'b00);
    drive(1, 1'b0, 32'h8, 32'h0, 2'b01);
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clock);
      if (bus.gnt != '0) begin
        order[ng] = bus.gnt[1] ? 1 : 0;
        gc[ng]    = cyc;
        ng++;
        if (ng == 4) bus.req = '0;
      end
    end
    chk("cont_grants", 64'(ng), 64'd4);
    if (ng == 4) begin
      chk("cont_order0", 64'(order[0]), 64'd0);
      chk("cont_order1", 64'(order[1]), 64'd1);
      chk("cont_order2", 64'(order[2]), 64'd0);
      chk("cont_order3", 64'(order[3]), 64'd1);
      for (int k = 1; k < 4; k++) chk("cont_spacing", 64'(gc[k] - gc[k-1]), 64'd3);
    end
    repeat (3) @(negedge clock);

    // Idle quiet, then confirm the pointer did not move (port 0 next).
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_mem_strobes", {bus.mem_re, bus.mem_we}, 2'b00);
    end
    drive(0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1, 1'b0, 32'h4, 32'h0, 2'b00);
    @(negedge clock);
    chk("idle_ptr_kept", bus.gnt, 2'b01);
    bus.req = '0;
    repeat (2) @(negedge clock);

    // Reset during RESP: no rvalid, pointer back to 0.
    drive(0, 1'b0, 32'h10, 32'h0, 2'b00);
    @(negedge clock);
    chk("rst_gnt", bus.gnt, 2'b01);
    bus.req = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_no_rvalid", bus.rvalid, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    drive(0, 1'b0, 32'h10, 32'h0, 2'b00);
    drive(1, 1'b0, 32'h14, 32'h0, 2'b00);
    @(negedge clock);
    chk("rst_ptr_zero", bus.gnt, 2'b01);
    bus.req = '0;
    repeat (2) @(negedge clock);
    drive(1, 1'b0, 32'h20, 32'h0, 2'b00);
    @(negedge clock);
    chk("rst_next_gnt", bus.gnt, 2'b10);
    bus.req = '0;
    repeat (2) @(negedge clock);
    chk("rst_next_rvalid", bus.rvalid, 2'b10);
    chk("rst_next_rdata", bus.rdata, 32'h12345678);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < N; p++) begin
        if (bus.gnt[p]) begin
          if ($urandom_range(0, 1) == 1) rand_payload(p);
          else bus.req[p] = 1'b0;
        end else if (!bus.req[p] && $urandom_range(0, 2) == 0) begin
          rand_payload(p);
        end
      end
    end
    reset = 1'b0;
    bus.req = '0;
    repeat (5) @(negedge clock);

`ifdef DMEM_ARB_PERF_EN
    // Three contended then two solo port-0 accesses.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1, 1'b0, 32'h4, 32'h0, 2'b00);
    ng = 0;
    for (int k = 0; k < 40 && ng < 5; k++) begin
      @(negedge clock);
      if (bus.gnt != '0) begin
        ng++;
        if (ng == 3) bus.req[1] = 1'b0;
        if (ng == 5) bus.req = '0;
      end
    end
    repeat (4) @(negedge clock);
    chk("perf_grants_seen", 64'(ng), 64'd5);
    chk("perf_gcnt0", bus.grant_count[0 +: CW], 64'd4);
    chk("perf_gcnt1", bus.grant_count[CW +: CW], 64'd1);
    chk("perf_gcnt0_model", bus.grant_count[0 +: CW], 64'(m_gcnt[0]));
    chk("perf_conflict", bus.conflict_count, 64'd3);
    chk("perf_conflict_model", bus.conflict_count, 64'(m_conf));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
